dtree_node_sequencer: RTL and testbench
=======================================

# dtree_node_sequencer

Sequences the shared node accumulator through an oblique decision-tree traversal for one spike feature vector. For each internal node it fetches the node word from the node ROM, loads the node bias, adds ±feature terms, and branches on the sign of the sum. It repeats this until it reaches a leaf, then reports the leaf's class. It sits between the feature extractor (upstream) and the classification output stage (downstream), and owns the only instance of the accumulator.

## Interface
- IN_WIDTH, 14: feature width, two's complement. The accumulator is IN_WIDTH+1 bits.
- N_FEATURES, 4: number of features per vector and number of term slots per node.
- NODE_AW, 6: node ROM address width. Nodes use heap indexing.
- CLASS_WIDTH, 3: class label width.
- MAX_DEPTH, 8: maximum number of internal nodes visited before the traversal aborts.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to classify `features`. Accepted only in IDLE.
- features  in  N_FEATURES*IN_WIDTH  feature vector. Feature i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- node_rd  out  1  node ROM read strobe.
- node_addr  out  NODE_AW  node ROM address.
- node_bias  in  IN_WIDTH+1  signed bias (−threshold). Valid one cycle after node_rd.
- node_coef  in  2*N_FEATURES  per-feature code: 00 skip, 01 +x, 11 −x, 10 skip (reserved).
- node_leaf  in  1  node is a leaf.
- node_class  in  CLASS_WIDTH  leaf class.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when the result is valid.
- class_out  out  CLASS_WIDTH  result class. Holds until the next accepted start.
- err  out  1  traversal aborted. Qualified by done.

## Operation
- **States:** IDLE, FETCH, LOAD, TERM, EVAL, DONE.
- **IDLE:**
  - On start: latch `features` into an internal register, set node index = 0 and depth = 0, clear class_out and err, then go to FETCH.
  - start is ignored in every other state.
- **FETCH:** node_rd=1 with node_addr = node index. Always go to LOAD next.
- **LOAD:** register node_coef, node_leaf and node_class.
  - If node_leaf=1: class_out ← node_class, go to DONE.
  - Else if depth = MAX_DEPTH: err ← 1, class_out ← 0, go to DONE.
  - Else: drive accumulator load=1, add=0, init=node_bias. Reset the term counter to 0 and go to TERM.
- **TERM:** runs for exactly N_FEATURES cycles, one feature per cycle (term t uses feature t). Accumulator load=0.
  - Code 01: add=1, a = x_t.
  - Code 11: add=1, a = −x_t. If x_t = −2^(IN_WIDTH−1), a = 2^(IN_WIDTH−1)−1 instead (saturated negation).
  - Code 00 or 10: add=0.
  - After term N_FEATURES−1, go to EVAL.
- **EVAL:** load=0, add=0, so the accumulator output y equals the accumulated sum.
  - y[IN_WIDTH]=1 (sum negative): child = 2i+1 (left).
  - y[IN_WIDTH]=0: child = 2i+2 (right).
  - If child > 2^NODE_AW−1: err ← 1, class_out ← 0, go to DONE.
  - Else: node index ← child, depth ← depth+1, go to FETCH.
- **DONE:** done=1 for one cycle, then go to IDLE.
- **Arithmetic:** accumulator arithmetic wraps in two's complement with no saturation. Keeping node sums in range is the tree generator's job.
- **Reset:** reset in any state, including mid-TERM, forces IDLE on the next edge. Reset values: busy 0, done 0, class_out 0, err 0, node_rd 0, node_addr 0, accumulator register 0. done is never produced for an interrupted traversal.

## Timing
- The edge that samples start is edge 0. FETCH occupies cycle 1.
- The node ROM has 1-cycle read latency: data presented in cycle c is read by LOAD in cycle c+1.
- An internal node costs N_FEATURES+3 cycles: FETCH, LOAD, N_FEATURES×TERM, EVAL.
- A leaf costs 2 cycles (FETCH, LOAD) followed by DONE.
- done is high in cycle k·(N_FEATURES+3)+3, where k is the number of internal nodes visited. The same formula applies to the MAX_DEPTH abort.
- An address-overflow abort reaches DONE one cycle after the EVAL that detects it.
- The earliest next start is accepted in the cycle after DONE.

## Structure
- **Shared package `dtree_pkg.vh`:**
  - state encodings
  - coefficient code localparams (COEF_SKIP, COEF_POS, COEF_NEG)
  - node word field offsets
  - saturated-negate helper function
- **One sub-module:** the existing `accumulator`, instantiated with IN_WIDTH unchanged.
- **Everything else is inline:** FSM, term counter, depth counter, feature register and negation mux.

## Test plan
All scenarios use the default parameters (IN_WIDTH=14, N_FEATURES=4).
- **Root leaf:** root is a leaf with class 5; start → done in cycle 3, class_out=5, err=0, busy high for cycles 1–3.
- **One internal node:** root bias −100, coef 01 on x0 only, x0=150; node 2 is a leaf with class 2 → sum 50 → right branch; done in cycle 10, class_out=2.
- **Saturated negation:** root bias 0, coef 11 on x1, x1=−8192 → a=8191, sum positive → node 2. Then x1=8 → sum −8 → node 1.
- **Address overflow:** NODE_AW=3, nodes 0, 2 and 6 are internal and all branch right; child 14 > 7 → err=1, class_out=0, done in cycle 22.
- **Start handling:** a second start during TERM is ignored. Changing `features` after the start edge does not change class_out. Back-to-back classification succeeds when start is held high in the cycle after DONE.
- **Reset mid-operation:** reset in the 2nd TERM cycle → busy=0 next cycle and no done pulse. A following start classifies correctly with the accumulator cleared.

Source files
------------

// File: rtl/dtree_node_sequencer_pkg.sv
// Shared definitions for the oblique decision-tree node sequencer.
//   state_t          : sequencer FSM states
//   COEF_*           : 2-bit per-feature term codes in a node word
//   node_*_lsb       : field offsets of a node word packed as
//                      {class, leaf, coef, bias} (bias at bit 0)
//   sat_neg          : two's-complement negate that maps the most negative
//                      value of a w-bit number to the most positive one
package dtree_node_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_TERM, S_EVAL, S_DONE
  } state_t;

  localparam logic [1:0] COEF_SKIP = 2'b00;
  localparam logic [1:0] COEF_POS  = 2'b01;
  localparam logic [1:0] COEF_RSVD = 2'b10;
  localparam logic [1:0] COEF_NEG  = 2'b11;

  localparam int NODE_BIAS_LSB = 0;

  function automatic int node_coef_lsb(input int in_width);
    return NODE_BIAS_LSB + in_width + 1;
  endfunction

  function automatic int node_leaf_bit(input int in_width, input int n_features);
    return node_coef_lsb(in_width) + 2 * n_features;
  endfunction

  function automatic int node_class_lsb(input int in_width, input int n_features);
    return node_leaf_bit(in_width, n_features) + 1;
  endfunction

  // x must be a sign-extended w-bit value; the low w bits of the result are
  // the saturated negation.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                 input int w);
    logic signed [31:0] min_v;
    min_v = 32'sh8000_0000 >>> (32 - w);
    return (x == min_v) ? ~min_v : -x;
  endfunction

endpackage

// File: rtl/dtree_node_sequencer_if.sv
// Node ROM read port.
//   node_rd/node_addr : read strobe and heap-indexed node address (master out)
//   node_bias         : signed node bias, valid the cycle after node_rd
//   node_coef         : 2-bit term code per feature
//   node_leaf         : node is a leaf
//   node_class        : class of a leaf node
interface dtree_node_sequencer_if #(
  parameter int IN_WIDTH    = 14,
  parameter int N_FEATURES  = 4,
  parameter int NODE_AW     = 6,
  parameter int CLASS_WIDTH = 3
);
  logic                          node_rd;
  logic [NODE_AW-1:0]            node_addr;
  logic signed [IN_WIDTH:0]      node_bias;
  logic [2*N_FEATURES-1:0]       node_coef;
  logic                          node_leaf;
  logic [CLASS_WIDTH-1:0]        node_class;

  modport master (
    output node_rd, node_addr,
    input  node_bias, node_coef, node_leaf, node_class
  );

  modport slave (
    input  node_rd, node_addr,
    output node_bias, node_coef, node_leaf, node_class
  );
endinterface

// File: rtl/dtree_node_sequencer_accumulator.sv
// Node accumulator: IN_WIDTH+1 bit register, wraps in two's complement.
//   clk, reset : clock, synchronous active-high reset (clears the register)
//   load, init : load the register with init (takes priority over add)
//   add, a     : add sign-extended IN_WIDTH-bit term a
//   y          : current register value
module dtree_node_sequencer_accumulator #(
  parameter int IN_WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       add,
  input  logic signed [IN_WIDTH:0]   init,
  input  logic signed [IN_WIDTH-1:0] a,
  output logic signed [IN_WIDTH:0]   y
);

  always_ff @(posedge clk) begin
    if (reset)     y <= '0;
    else if (load) y <= init;
    else if (add)  y <= y + {a[IN_WIDTH-1], a};
  end

endmodule

// File: rtl/dtree_node_sequencer.sv
// Oblique decision-tree traversal for one feature vector.
//   clk, reset : clock, synchronous active-high reset
//   start      : classify `features` (accepted only when idle)
//   features   : N_FEATURES x IN_WIDTH signed features, feature i at i*IN_WIDTH
//   rom        : node ROM read port (1-cycle latency)
//   busy       : traversal in progress
//   done       : one-cycle result pulse
//   class_out  : leaf class, 0 on abort; held until the next accepted start
//   err        : traversal aborted (depth limit or address overflow)
// Per internal node: FETCH, LOAD (acc <= bias), N_FEATURES x TERM, EVAL.
module dtree_node_sequencer
  import dtree_node_sequencer_pkg::*;
#(
  parameter int IN_WIDTH    = 14,
  parameter int N_FEATURES  = 4,
  parameter int NODE_AW     = 6,
  parameter int CLASS_WIDTH = 3,
  parameter int MAX_DEPTH   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [N_FEATURES*IN_WIDTH-1:0]   features,
  dtree_node_sequencer_if.master           rom,
  output logic                             busy,
  output logic                             done,
  output logic [CLASS_WIDTH-1:0]           class_out,
  output logic                             err
);

  localparam int TW = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
  localparam int DW = $clog2(MAX_DEPTH + 1);
  // 2*i+2 for the largest index needs two more bits than the index
  localparam int CW = NODE_AW + 2;
  localparam logic signed [IN_WIDTH:0] ACC_ZERO = '0;

  state_t                          state;
  logic [N_FEATURES*IN_WIDTH-1:0]  feat_q;
  logic [2*N_FEATURES-1:0]         coef_q;
  logic [TW-1:0]                   term_q;
  logic [DW-1:0]                   depth_q;
  logic [NODE_AW-1:0]              idx_q;
  logic                            rd_q;

  logic                            acc_load;
  logic                            acc_add;
  logic signed [IN_WIDTH-1:0]      acc_a;
  logic signed [IN_WIDTH:0]        acc_y;

  logic signed [IN_WIDTH-1:0]      x_t;
  logic signed [IN_WIDTH-1:0]      neg_x;
  logic [1:0]                      code_t;
  logic                            go_left;
  logic [CW-1:0]                   child;
  logic                            child_ovf;

  assign rom.node_rd   = rd_q;
  assign rom.node_addr = idx_q;

  assign x_t    = feat_q[term_q*IN_WIDTH +: IN_WIDTH];
  assign code_t = coef_q[term_q*2 +: 2];
  assign neg_x  = IN_WIDTH'(sat_neg(32'(x_t), IN_WIDTH));

  assign go_left   = (acc_y < ACC_ZERO);
  assign child     = {1'b0, idx_q, 1'b0} + (go_left ? CW'(1) : CW'(2));
  assign child_ovf = |child[CW-1:NODE_AW];

  // Accumulator controls decode straight from the registered state so the
  // bias is captured in the same cycle the ROM presents it.
  always_comb begin
    acc_load = (state == S_LOAD) && !rom.node_leaf && (depth_q != DW'(MAX_DEPTH));
    acc_add  = 1'b0;
    acc_a    = x_t;
    if (state == S_TERM) begin
      case (code_t)
        COEF_POS:             acc_add = 1'b1;
        COEF_NEG:  begin      acc_add = 1'b1; acc_a = neg_x; end
        COEF_SKIP, COEF_RSVD: acc_add = 1'b0;
        default:              acc_add = 1'b0;
      endcase
    end
  end

  dtree_node_sequencer_accumulator #(.IN_WIDTH(IN_WIDTH)) u_acc (
    .clk  (clk),
    .reset(reset),
    .load (acc_load),
    .add  (acc_add),
    .init (rom.node_bias),
    .a    (acc_a),
    .y    (acc_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      feat_q    <= '0;
      coef_q    <= '0;
      term_q    <= '0;
      depth_q   <= '0;
      idx_q     <= '0;
      rd_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_out <= '0;
      err       <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          feat_q    <= features;
          idx_q     <= '0;
          depth_q   <= '0;
          class_out <= '0;
          err       <= 1'b0;
          rd_q      <= 1'b1;
          busy      <= 1'b1;
          state     <= S_FETCH;
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          coef_q <= rom.node_coef;
          term_q <= '0;
          if (rom.node_leaf) begin
            class_out <= rom.node_class;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (depth_q == DW'(MAX_DEPTH)) begin
            err       <= 1'b1;
            class_out <= '0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_TERM;
          end
        end
        S_TERM: begin
          term_q <= term_q + 1'b1;
          if (term_q == TW'(N_FEATURES - 1)) state <= S_EVAL;
        end
        S_EVAL: begin
          if (child_ovf) begin
            err       <= 1'b1;
            class_out <= '0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx_q   <= child[NODE_AW-1:0];
            depth_q <= depth_q + 1'b1;
            rd_q    <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_node_sequencer.sv
module tb_dtree_node_sequencer;
  localparam int IW  = 14;
  localparam int NF  = 4;
  localparam int CLW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start3 = 1'b0;
  logic [NF*IW-1:0] features = '0;
  logic busy, done, err, busy3, done3, err3;
  logic [CLW-1:0] class_out, class3;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dtree_node_sequencer_if #(.IN_WIDTH(IW), .N_FEATURES(NF), .NODE_AW(6), .CLASS_WIDTH(CLW)) rom_if ();
  dtree_node_sequencer_if #(.IN_WIDTH(IW), .N_FEATURES(NF), .NODE_AW(3), .CLASS_WIDTH(CLW)) rom3_if ();

  dtree_node_sequencer #(.IN_WIDTH(IW), .N_FEATURES(NF), .NODE_AW(6), .CLASS_WIDTH(CLW), .MAX_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .features(features), .rom(rom_if),
    .busy(busy), .done(done), .class_out(class_out), .err(err));

  // Small tree instance: NODE_AW=3 for address overflow, MAX_DEPTH=3 for the depth abort
  dtree_node_sequencer #(.IN_WIDTH(IW), .N_FEATURES(NF), .NODE_AW(3), .CLASS_WIDTH(CLW), .MAX_DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .features(features), .rom(rom3_if),
    .busy(busy3), .done(done3), .class_out(class3), .err(err3));

  logic signed [IW:0] rb [64];
  logic [2*NF-1:0]    rc [64];
  logic               rl [64];
  logic [CLW-1:0]     rk [64];
  logic signed [IW:0] rb3 [8];
  logic [2*NF-1:0]    rc3 [8];
  logic               rl3 [8];
  logic [CLW-1:0]     rk3 [8];

  always @(posedge clk) if (rom_if.node_rd) begin
    rom_if.node_bias  <= rb[rom_if.node_addr];
    rom_if.node_coef  <= rc[rom_if.node_addr];
    rom_if.node_leaf  <= rl[rom_if.node_addr];
    rom_if.node_class <= rk[rom_if.node_addr];
  end

  always @(posedge clk) if (rom3_if.node_rd) begin
    rom3_if.node_bias  <= rb3[rom3_if.node_addr];
    rom3_if.node_coef  <= rc3[rom3_if.node_addr];
    rom3_if.node_leaf  <= rl3[rom3_if.node_addr];
    rom3_if.node_class <= rk3[rom3_if.node_addr];
  end

  function automatic logic [NF*IW-1:0] fv(input int x0, input int x1, input int x2, input int x3);
    logic [IW-1:0] a0, a1, a2, a3;
    a0 = IW'(x0); a1 = IW'(x1); a2 = IW'(x2); a3 = IW'(x3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < 64; i++) begin rb[i] = '0; rc[i] = '0; rl[i] = 1'b0; rk[i] = '0; end
    for (int i = 0; i < 8; i++) begin rb3[i] = '0; rc3[i] = '0; rl3[i] = 1'b0; rk3[i] = '0; end
  endtask

  // Root bias -100, +x0 only; node 1 leaf class 3, node 2 leaf class 2
  task automatic rom_one_internal();
    rom_clear();
    rb[0] = -15'sd100; rc[0] = 8'b00_00_00_01;
    rl[1] = 1'b1; rk[1] = 3'd3;
    rl[2] = 1'b1; rk[2] = 3'd2;
  endtask

  // Pulse start; lat = cycle of done (edge sampling start is edge 0), 0 on timeout.
  // busy_bits[n-1] = busy in cycle n; extra_done = done in cycle lat+1.
  task automatic classify(input bit sel, input logic [NF*IW-1:0] f, output int lat,
                          output logic [15:0] busy_bits, output logic extra_done);
    lat = 0; busy_bits = '0; extra_done = 1'b0;
    features = f;
    @(negedge clk);
    if (sel) start3 = 1'b1; else start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; start3 = 1'b0; end
      if (n <= 16) busy_bits[n-1] = sel ? busy3 : busy;
      if (lat != 0) begin extra_done = sel ? done3 : done; break; end
      if (sel ? done3 : done) lat = n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (class_out !== 3'd0) begin failures++; $display("FAIL reset_class got=%0d want=0", class_out); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (rom_if.node_rd !== 1'b0) begin failures++; $display("FAIL reset_node_rd got=%b want=0", rom_if.node_rd); end
    checks++; if (rom_if.node_addr !== 6'd0) begin failures++; $display("FAIL reset_node_addr got=%0d want=0", rom_if.node_addr); end
    checks++; if (dut.acc_y !== 15'sd0) begin failures++; $display("FAIL reset_acc got=%0d want=0", dut.acc_y); end
  endtask

  task automatic test_root_leaf();
    int lat; logic [15:0] bb; logic xd;
    rom_clear(); rl[0] = 1'b1; rk[0] = 3'd5;
    classify(1'b0, fv(1, 2, 3, 4), lat, bb, xd);
    checks++; if (lat !== 3) begin failures++; $display("FAIL root_leaf_lat got=%0d want=3", lat); end
    checks++; if (class_out !== 3'd5) begin failures++; $display("FAIL root_leaf_class got=%0d want=5", class_out); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL root_leaf_err got=%b want=0", err); end
    checks++; if (bb[3:0] !== 4'b0111) begin failures++; $display("FAIL root_leaf_busy got=%b want=0111", bb[3:0]); end
    checks++; if (xd !== 1'b0) begin failures++; $display("FAIL root_leaf_done_width got=%b want=0", xd); end
  endtask

  task automatic test_one_internal();
    int lat; logic [15:0] bb; logic xd;
    rom_one_internal();
    rc[0] = 8'b10_00_00_01;  // reserved code on x3 must be skipped
    classify(1'b0, fv(150, 1000, -5, 77), lat, bb, xd);  // -100+150 = 50 -> right
    checks++; if (lat !== 10) begin failures++; $display("FAIL internal_right_lat got=%0d want=10", lat); end
    checks++; if (class_out !== 3'd2) begin failures++; $display("FAIL internal_right_class got=%0d want=2", class_out); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL internal_right_err got=%b want=0", err); end
    classify(1'b0, fv(50, 1000, -5, 77), lat, bb, xd);   // -50 -> left
    checks++; if (lat !== 10) begin failures++; $display("FAIL internal_left_lat got=%0d want=10", lat); end
    checks++; if (class_out !== 3'd3) begin failures++; $display("FAIL internal_left_class got=%0d want=3", class_out); end
    checks++; if (bb[10:0] !== 11'b011_1111_1111) begin failures++; $display("FAIL internal_busy got=%b want=01111111111", bb[10:0]); end
  endtask

  task automatic test_sat_neg();
    int lat; logic [15:0] bb; logic xd;
    rom_one_internal();
    rb[0] = 15'sd0; rc[0] = 8'b00_00_11_00;
    classify(1'b0, fv(0, -8192, 0, 0), lat, bb, xd);     // a = 8191 -> right
    checks++; if (class_out !== 3'd2 || lat !== 10) begin failures++; $display("FAIL sat_neg_min class=%0d lat=%0d want class=2 lat=10", class_out, lat); end
    classify(1'b0, fv(0, 8, 0, 0), lat, bb, xd);         // -8 -> left
    checks++; if (class_out !== 3'd3) begin failures++; $display("FAIL sat_neg_small got=%0d want=3", class_out); end
    rb[0] = 15'sd16383; rc[0] = 8'b00_00_00_01;          // 16383+1 wraps negative -> left
    classify(1'b0, fv(1, 0, 0, 0), lat, bb, xd);
    checks++; if (class_out !== 3'd3) begin failures++; $display("FAIL acc_wrap got=%0d want=3", class_out); end
  endtask

  task automatic test_multi_term();
    int lat; logic [15:0] bb; logic xd;
    rom_one_internal();
    rb[0] = 15'sd10; rc[0] = 8'b11_01_11_01;             // +x0 -x1 +x2 -x3
    classify(1'b0, fv(100, 200, 50, -30), lat, bb, xd);  // 10+100-200+50+30 = -10 -> left
    checks++; if (class_out !== 3'd3) begin failures++; $display("FAIL multi_term_neg got=%0d want=3", class_out); end
    classify(1'b0, fv(100, 200, 50, -40), lat, bb, xd);  // sum 0 counts as non-negative -> right
    checks++; if (class_out !== 3'd2) begin failures++; $display("FAIL multi_term_zero got=%0d want=2", class_out); end
  endtask

  task automatic test_start_handling();
    int lat = 0; int lat2 = 0;
    logic [CLW-1:0] c1 = '0;
    logic b_after = 1'bx;
    rom_one_internal();
    features = fv(150, 0, 0, 0);
    @(negedge clk); start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; features = fv(0, 0, 0, 0); end
      if (n == 4) start = 1'b1;                 // lands in TERM
      if (n == 5) start = 1'b0;
      if (lat != 0 && n == lat + 1) b_after = busy;
      if (lat != 0 && n == lat + 2) start = 1'b0;
      if (lat != 0 && n > lat && done) begin lat2 = n; break; end
      if (lat == 0 && done) begin lat = n; c1 = class_out; start = 1'b1; end
    end
    start = 1'b0;
    checks++; if (lat !== 10) begin failures++; $display("FAIL start_ignore_lat got=%0d want=10", lat); end
    checks++; if (c1 !== 3'd2) begin failures++; $display("FAIL feature_latch got=%0d want=2", c1); end
    checks++; if (b_after !== 1'b0) begin failures++; $display("FAIL idle_after_done got=%b want=0", b_after); end
    checks++; if (lat2 !== 21) begin failures++; $display("FAIL back_to_back_lat got=%0d want=21", lat2); end
    checks++; if (class_out !== 3'd3) begin failures++; $display("FAIL back_to_back_class got=%0d want=3", class_out); end
    @(negedge clk);
  endtask

  task automatic test_small_tree();
    int lat; logic [15:0] bb; logic xd;
    rom_clear();                                         // all internal, bias 0 -> always right
    classify(1'b1, fv(5, 6, 7, 8), lat, bb, xd);         // 0 -> 2 -> 6 -> 14 overflows
    checks++; if (lat !== 22) begin failures++; $display("FAIL overflow_lat got=%0d want=22", lat); end
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL overflow_err got=%b want=1", err3); end
    checks++; if (class3 !== 3'd0) begin failures++; $display("FAIL overflow_class got=%0d want=0", class3); end
    rb3[0] = -15'sd1; rb3[1] = -15'sd1; rb3[3] = -15'sd1;  // 0 -> 1 -> 3 -> 7, depth limit at 7
    rl3[7] = 1'b0; rk3[7] = 3'd4;
    classify(1'b1, fv(5, 6, 7, 8), lat, bb, xd);
    checks++; if (lat !== 24) begin failures++; $display("FAIL max_depth_lat got=%0d want=24", lat); end
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL max_depth_err got=%b want=1", err3); end
    checks++; if (class3 !== 3'd0) begin failures++; $display("FAIL max_depth_class got=%0d want=0", class3); end
    rl3[0] = 1'b1; rk3[0] = 3'd6;
    classify(1'b1, fv(5, 6, 7, 8), lat, bb, xd);
    checks++; if (lat !== 3) begin failures++; $display("FAIL err_clear_lat got=%0d want=3", lat); end
    checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL err_clear_err got=%b want=0", err3); end
    checks++; if (class3 !== 3'd6) begin failures++; $display("FAIL err_clear_class got=%0d want=6", class3); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] bb; logic xd;
    logic b5 = 1'bx; logic rd5 = 1'bx; logic saw_done = 1'b0;
    logic signed [IW:0] acc5 = 'x;
    rom_one_internal();
    features = fv(150, 0, 0, 0);
    @(negedge clk); start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 4) reset = 1'b1;                 // second TERM cycle
      if (n == 5) begin b5 = busy; rd5 = rom_if.node_rd; acc5 = dut.acc_y; reset = 1'b0; end
      if (n >= 3 && done) saw_done = 1'b1;
    end
    checks++; if (b5 !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got=%b want=0", b5); end
    checks++; if (rd5 !== 1'b0) begin failures++; $display("FAIL reset_mid_rd got=%b want=0", rd5); end
    checks++; if (acc5 !== 15'sd0) begin failures++; $display("FAIL reset_mid_acc got=%0d want=0", acc5); end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL reset_mid_done got=%b want=0", saw_done); end
    classify(1'b0, fv(150, 0, 0, 0), lat, bb, xd);
    checks++; if (lat !== 10) begin failures++; $display("FAIL after_reset_lat got=%0d want=10", lat); end
    checks++; if (class_out !== 3'd2) begin failures++; $display("FAIL after_reset_class got=%0d want=2", class_out); end
  endtask

  initial begin
    rom_clear();
    test_reset();
    test_root_leaf();
    test_one_internal();
    test_sat_neg();
    test_multi_term();
    test_start_handling();
    test_small_tree();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
